// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/forward sequencer with data-memory wait FSM (optional PIPE_PERF_CNT_EN)
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs1_D,
  input  logic [4:0]        rs2_D,
  input  logic [4:0]        rs1_E,
  input  logic [4:0]        rs2_E,
  input  logic [4:0]        rd_E,
  input  logic              is_load_E,
  input  logic              pc_src_E,
  input  logic [4:0]        rd_M,
  input  logic [4:0]        rd_W,
  input  logic              reg_write_M,
  input  logic              reg_write_W,
  input  logic              mem_req_M,
  input  logic              mem_ready,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_D,
  output logic              stall_E,
  output logic              flush_E,
  output logic              stall_M,
  output logic              flush_W,
  output logic [1:0]        fwd_a_E,
  output logic [1:0]        fwd_b_E,
  output logic              mem_err,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             mem_err_q;
  logic             mem_stall;
  logic             load_use;

  // Data-memory wait-state FSM; ERR only leaves through reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req_M && !mem_ready) begin
            state_q    <= WAIT;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_q   <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;

  // Memory freeze is visible in the same cycle the access first misses
  always_comb begin
    mem_stall = (state_q == WAIT) || (state_q == ERR) ||
                ((state_q == IDLE) && mem_req_M && !mem_ready);
    load_use  = is_load_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
  end

  // Stall/flush priority: memory freeze, then taken branch, then load-use bubble
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    stall_E = 1'b0;
    flush_E = 1'b0;
    stall_M = 1'b0;
    flush_W = 1'b0;
    if (reset) begin
      if (mem_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (pc_src_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // EX operand bypass: MEM result is younger, so it beats WB; x0 never bypasses
  always_comb begin
    fwd_a_E = 2'b00;
    fwd_b_E = 2'b00;
    if (reset) begin
      if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs1_E))      fwd_a_E = 2'b10;
      else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs1_E)) fwd_a_E = 2'b01;
      if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs2_E))      fwd_b_E = 2'b10;
      else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs2_E)) fwd_b_E = 2'b01;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments so a long run never wraps back to a small count
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_F && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (flush_D && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
